reg_scoreboard: RTL and testbench

Issue-stage hazard controller for the integer register file. It decodes the Rd, Rn and Rm fields of the 32-bit instruction word into one-hot register selects. It keeps a busy bit per architectural register and holds issue until every source and the destination are free of outstanding writes. It sits between instruction fetch/decode and the register-file read stage, and releases busy bits as one-hot writeback selects return from the write stage.

---
 rtl/reg_pkg.sv | 28 ++
 rtl/reg_onehot_dec.sv | 14 +
 rtl/reg_scoreboard.sv | 89 ++++++++
 tb/tb_reg_scoreboard.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared definitions for the register scoreboard: instruction field positions,
// the zero-register index and the field splitter used by the decode stage.
package reg_pkg;

  localparam int NREGS_DEF = 32;
  localparam int FIELD_W   = 5;
  localparam int RD_LSB    = 0;
  localparam int RN_LSB    = 5;
  localparam int RM_LSB    = 16;
  localparam int XZR_IDX   = 31;

  typedef logic [FIELD_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t rm;
    reg_idx_t rn;
    reg_idx_t rd;
  } reg_fields_t;

  function automatic reg_fields_t split_fields(input logic [31:0] ibus);
    reg_fields_t f;
    f.rd = ibus[RD_LSB +: FIELD_W];
    f.rn = ibus[RN_LSB +: FIELD_W];
    f.rm = ibus[RM_LSB +: FIELD_W];
    return f;
  endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// Register-field decoder: turns a 5-bit register index into an NREGS-wide
// one-hot select (all zeros when the index is beyond NREGS).
module reg_onehot_dec
  import reg_pkg::*;
#(
  parameter int NREGS = NREGS_DEF
) (
  input  logic [FIELD_W-1:0] i_field,
  output logic [NREGS-1:0]   o_onehot
);

  assign o_onehot = NREGS'(1) << i_field;

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-stage hazard controller: per-register busy bits, RAW/WAW stall and a
// saturating stall counter. Define REG_SCOREBOARD_FWD_EN to let a same-cycle
// writeback free its register for the hazard check (needs register-file bypass).
module reg_scoreboard
  import reg_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ibus,
  input  logic             iss_valid,
  input  logic             uses_rn,
  input  logic             uses_rm,
  input  logic             writes_rd,
  output logic             iss_ready,
  output logic [NREGS-1:0] rn_sel,
  output logic [NREGS-1:0] rm_sel,
  output logic [NREGS-1:0] rd_sel,
  input  logic             wb_valid,
  input  logic [NREGS-1:0] wb_sel,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [NREGS-1:0] XZR_MASK =
    (XZR_IDX < NREGS) ? (NREGS'(1) << XZR_IDX) : '0;

  reg_fields_t      w_fields;
  logic [NREGS-1:0] w_wb_clr;
  logic [NREGS-1:0] w_busy_eff;
  logic [NREGS-1:0] w_busy_set;
  logic [NREGS-1:0] w_busy_nxt;
  logic             w_src_haz;
  logic             w_waw_haz;
  logic             w_issue;
  logic             w_stall;
  logic [NREGS-1:0] r_busy;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_fields = split_fields(ibus);

  reg_onehot_dec #(.NREGS(NREGS)) u_dec_rd (.i_field(w_fields.rd), .o_onehot(rd_sel));
  reg_onehot_dec #(.NREGS(NREGS)) u_dec_rn (.i_field(w_fields.rn), .o_onehot(rn_sel));
  reg_onehot_dec #(.NREGS(NREGS)) u_dec_rm (.i_field(w_fields.rm), .o_onehot(rm_sel));

  assign w_wb_clr = wb_valid ? wb_sel : '0;

`ifdef REG_SCOREBOARD_FWD_EN
  assign w_busy_eff = r_busy & ~w_wb_clr;
`else
  assign w_busy_eff = r_busy;
`endif

  assign w_src_haz = (uses_rn && |(w_busy_eff & rn_sel)) ||
                     (uses_rm && |(w_busy_eff & rm_sel));
  assign w_waw_haz = writes_rd && |(w_busy_eff & rd_sel);

  assign iss_ready = iss_valid && !flush && !w_src_haz && !w_waw_haz;
  assign w_issue   = iss_valid && iss_ready;
  assign w_stall   = iss_valid && !iss_ready;

  // NOTE: every always_comb output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_busy_set = '0;
    if (w_issue && writes_rd) w_busy_set = rd_sel & ~XZR_MASK;
    // Clear before set: a register re-issued in its writeback cycle stays busy.
    w_busy_nxt = flush ? '0 : ((r_busy & ~w_wb_clr) | w_busy_set);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign busy      = r_busy;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios with literal
// expectations, then random traffic against a per-register behavioural model.
module tb_reg_scoreboard;

`ifdef REG_SCOREBOARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ibus;
  logic        iss_valid, uses_rn, uses_rm, writes_rd;
  logic        wb_valid, flush;
  logic [31:0] wb_sel;

  logic        iss_ready, iss_ready4;
  logic [31:0] rn_sel, rm_sel, rd_sel, busy;
  logic [31:0] rn_sel4, rm_sel4, rd_sel4, busy4;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt4;

  int errors = 0;
  int checks = 0;

  reg_scoreboard #(.NREGS(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ibus(ibus), .iss_valid(iss_valid),
    .uses_rn(uses_rn), .uses_rm(uses_rm), .writes_rd(writes_rd),
    .iss_ready(iss_ready), .rn_sel(rn_sel), .rm_sel(rm_sel), .rd_sel(rd_sel),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .flush(flush),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  reg_scoreboard #(.NREGS(32), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .ibus(ibus), .iss_valid(iss_valid),
    .uses_rn(uses_rn), .uses_rm(uses_rm), .writes_rd(writes_rd),
    .iss_ready(iss_ready4), .rn_sel(rn_sel4), .rm_sel(rm_sel4), .rd_sel(rd_sel4),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .flush(flush),
    .busy(busy4), .stall_cnt(stall_cnt4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input bit v, input bit urn, input bit urm, input bit wr,
                           input int rd, input int rn, input int rm);
    logic [31:0] w;
    w = $urandom;
    w[4:0]   = rd[4:0];
    w[9:5]   = rn[4:0];
    w[20:16] = rm[4:0];
    ibus = w; iss_valid = v; uses_rn = urn; uses_rm = urm; writes_rd = wr;
  endtask

  task automatic idle();
    set_instr(0, 0, 0, 0, 0, 0, 0);
    wb_valid = 0; wb_sel = '0; flush = 0;
  endtask

  // Behavioural model: one busy flag per register and an unbounded stall count.
  bit          m_busy [32];
  int          m_cnt;
  bit          m_free [32];
  bit          m_rdy;
  int          m_rd, m_rn, m_rm;
  logic [31:0] m_busy_vec;

  always @(negedge clk) begin
    if (reset) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_cnt = 0;
    end
    m_rd = int'(ibus[4:0]);
    m_rn = int'(ibus[9:5]);
    m_rm = int'(ibus[20:16]);
    foreach (m_busy[i]) m_free[i] = !m_busy[i] || (FWD && wb_valid && wb_sel[i]);
    m_rdy = iss_valid && !flush && !(uses_rn && !m_free[m_rn]) &&
            !(uses_rm && !m_free[m_rm]) && !(writes_rd && !m_free[m_rd]);
    foreach (m_busy[i]) m_busy_vec[i] = m_busy[i];

    check("rd_sel", rd_sel, 64'(2.0 ** m_rd));
    check("rn_sel", rn_sel, 64'(2.0 ** m_rn));
    check("rm_sel", rm_sel, 64'(2.0 ** m_rm));
    check("iss_ready", iss_ready, m_rdy);
    check("iss_ready4", iss_ready4, m_rdy);
    check("busy", busy, m_busy_vec);
    check("busy4", busy4, m_busy_vec);
    check("stall_cnt", stall_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
    check("stall_cnt4", stall_cnt4, (m_cnt > 15) ? 15 : m_cnt);

    if (!reset) begin
      if (iss_valid && !m_rdy) m_cnt++;
      if (flush) begin
        foreach (m_busy[i]) m_busy[i] = 0;
      end else begin
        foreach (m_busy[i]) if (wb_valid && wb_sel[i]) m_busy[i] = 0;
        if (iss_valid && m_rdy && writes_rd && m_rd != 31) m_busy[m_rd] = 1;
      end
    end
  end

  initial begin
    reset = 1;
    idle();
    #1;
    check("reset_busy", busy, 32'h0);
    check("reset_cnt", stall_cnt, 16'h0);
    step(); step();
    reset = 0;

    // Reset mid-stall with busy = 0xF0.
    for (int k = 4; k < 8; k++) begin
      set_instr(1, 0, 0, 1, k, 0, 0);
      step();
    end
    set_instr(1, 1, 0, 0, 0, 4, 0);
    #1;
    check("busy_f0", busy, 32'h0000_00F0);
    step(); step();
    check("cnt_before_reset", stall_cnt, 16'd2);
    reset = 1;
    #1;
    check("async_busy", busy, 32'h0);
    check("async_cnt", stall_cnt, 16'h0);
    step(); step();
    reset = 0;
    #1;
    check("ready_after_reset", iss_ready, 1'b1);
    step();

    // RAW stall on X3.
    set_instr(1, 0, 0, 1, 3, 0, 0);
    step();
    set_instr(1, 0, 1, 0, 0, 0, 3);
    #1;
    check("raw_busy3", busy, 32'h8);
    check("raw_stall", iss_ready, 1'b0);
    step(); check("raw_cnt1", stall_cnt, 16'd1);
    step(); check("raw_cnt2", stall_cnt, 16'd2);
    step(); check("raw_cnt3", stall_cnt, 16'd3);
    wb_valid = 1; wb_sel = 32'h8;
    #1;
    check("raw_wb_ready", iss_ready, FWD);
    step();
    wb_valid = 0; wb_sel = '0;
    if (!FWD) begin
      #1;
      check("raw_after_wb_ready", iss_ready, 1'b1);
      step();
    end
    idle();
    #1;
    check("raw_cnt_final", stall_cnt, FWD ? 16'd3 : 16'd4);

    // XZR never busy, never stalls.
    set_instr(1, 0, 0, 1, 31, 0, 0);
    step();
    set_instr(1, 1, 0, 0, 0, 31, 0);
    #1;
    check("xzr_busy", busy, 32'h0);
    check("xzr_ready", iss_ready, 1'b1);
    step();

    // Same-cycle set and clear of X5.
    set_instr(1, 0, 0, 1, 5, 0, 0);
    step();
    wb_valid = 1; wb_sel = 32'h20;
    #1;
    check("setclr_ready", iss_ready, FWD);
    step();
    idle();
    #1;
    check("setclr_busy", busy, FWD ? 32'h20 : 32'h0);
    wb_valid = 1; wb_sel = 32'h20;
    step();
    idle();

    // Flush with busy = 0xF0F.
    for (int k = 0; k < 12; k++) begin
      if (k < 4 || k >= 8) begin
        set_instr(1, 0, 0, 1, k, 0, 0);
        step();
      end
    end
    set_instr(1, 0, 0, 1, 20, 0, 0);
    flush = 1;
    #1;
    check("flush_busy_pre", busy, 32'h0000_0F0F);
    check("flush_ready", iss_ready, 1'b0);
    step();
    idle();
    #1;
    check("flush_busy_post", busy, 32'h0);

    // Saturation of the 4-bit counter.
    set_instr(1, 0, 0, 1, 7, 0, 0);
    step();
    set_instr(1, 1, 0, 0, 0, 7, 0);
    repeat (20) step();
    check("sat_cnt4", stall_cnt4, 4'hF);
    step();
    check("sat_hold", stall_cnt4, 4'hF);
    idle();
    flush = 1;
    step();
    idle();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      if (reset) reset = 0;
      else if ($urandom_range(199) == 0) reset = 1;
      r = $urandom_range(3);
      set_instr($urandom_range(9) < 7, $urandom_range(1), $urandom_range(1),
                $urandom_range(1),
                (r == 0) ? 31 : $urandom_range(7),
                ($urandom_range(7) == 0) ? 31 : $urandom_range(7),
                $urandom_range(7));
      wb_valid = $urandom_range(9) < 4;
      r = $urandom_range(9);
      wb_sel = (r == 0) ? 32'h0 : (r == 1) ? 32'($urandom) : (32'h1 << $urandom_range(7));
      flush = $urandom_range(31) == 0;
      step();
    end
    reset = 0;
    idle();
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
